// File: rtl/dca_matrix_lsu_arbiter_pkg.sv
// Shared types for the DCA matrix LSU arbiter.
// State encoding, instruction width and index-width helper.
package dca_matrix_lsu_arbiter_pkg;

    localparam int BW_DCA_MATRIX_LSU_INST = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_LSU = 2'd1,
        ST_ISSUE    = 2'd2,
        ST_RELOCK   = 2'd3
    } arb_state_e;

    // Bits needed to hold an index 0..n-1 (at least 1).
    function automatic int req_index_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dca_matrix_lsu_arbiter_if.sv
// Requester and LSU side signals of the DCA matrix LSU arbiter.
// slave: the arbiter; master: requesters plus LSU.
interface dca_matrix_lsu_arbiter_if
    import dca_matrix_lsu_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BW_INST      = BW_DCA_MATRIX_LSU_INST,
    parameter int BW_REQ_INDEX = req_index_bits(NUM_REQ)
);

    logic [NUM_REQ-1:0]         req_inst_valid;
    logic [NUM_REQ*BW_INST-1:0] req_inst_list;
    logic [NUM_REQ-1:0]         req_lock;
    logic [NUM_REQ-1:0]         req_inst_ready;
    logic                       lsu_busy;
    logic                       lsu_inst_valid;
    logic [BW_INST-1:0]         lsu_inst;
    logic                       lsu_inst_ready;
    logic [NUM_REQ-1:0]         grant_onehot;
    logic [BW_REQ_INDEX-1:0]    grant_index;
    logic                       arb_busy;

    modport slave (
        input  req_inst_valid,
        input  req_inst_list,
        input  req_lock,
        input  lsu_busy,
        input  lsu_inst_ready,
        output req_inst_ready,
        output lsu_inst_valid,
        output lsu_inst,
        output grant_onehot,
        output grant_index,
        output arb_busy
    );

    modport master (
        output req_inst_valid,
        output req_inst_list,
        output req_lock,
        output lsu_busy,
        output lsu_inst_ready,
        input  req_inst_ready,
        input  lsu_inst_valid,
        input  lsu_inst,
        input  grant_onehot,
        input  grant_index,
        input  arb_busy
    );

endinterface

// File: rtl/dca_rr_picker.sv
// Combinational round-robin picker: lowest requester index
// at or after the pointer wins, wrapping at NUM_REQ.
module dca_rr_picker
    import dca_matrix_lsu_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BW_REQ_INDEX = req_index_bits(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]      req,
    input  logic [BW_REQ_INDEX-1:0] pointer,
    output logic [NUM_REQ-1:0]      onehot,
    output logic [BW_REQ_INDEX-1:0] index,
    output logic                    any
);

    localparam int BW_POS = BW_REQ_INDEX + 1;

    logic [BW_POS-1:0] pos;

    // Scan from the pointer upward; first hit wins.
    always_comb begin
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        pos    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, pointer} + BW_POS'(k);
            if (pos >= BW_POS'(NUM_REQ)) begin
                pos = pos - BW_POS'(NUM_REQ);
            end
            if (!any && req[pos[BW_REQ_INDEX-1:0]]) begin
                any = 1'b1;
                onehot[pos[BW_REQ_INDEX-1:0]] = 1'b1;
                index = pos[BW_REQ_INDEX-1:0];
            end
        end
    end

endmodule

// File: rtl/dca_matrix_lsu_arbiter.sv
// Shares one DCA matrix LSU between NUM_REQ requesters with
// round-robin arbitration and optional capped grant locking.
module dca_matrix_lsu_arbiter
    import dca_matrix_lsu_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BW_INST      = BW_DCA_MATRIX_LSU_INST,
    parameter int MAX_BURST    = 4,
    parameter int BW_REQ_INDEX = req_index_bits(NUM_REQ)
) (
    input logic clk,
    input logic rstnn,
    input logic enable,
    dca_matrix_lsu_arbiter_if.slave bus
);

    localparam int BW_BURST = $clog2(MAX_BURST + 1);

    arb_state_e                state, state_nx;
    logic [NUM_REQ-1:0]        grant, grant_nx;
    logic [BW_REQ_INDEX-1:0]   owner, owner_nx;
    logic [BW_REQ_INDEX-1:0]   rr_pointer, rr_pointer_nx;
    logic [BW_REQ_INDEX-1:0]   next_pointer;
    logic [BW_BURST-1:0]       burst_count, burst_nx;
    logic [BW_INST-1:0]        inst_reg, inst_nx;
    logic [BW_INST-1:0]        pick_inst, owner_inst;
    logic [NUM_REQ-1:0]        pick_onehot;
    logic [BW_REQ_INDEX-1:0]   pick_index;
    logic                      pick_any;
    logic                      done;
    logic                      can_lock;

    dca_rr_picker #(
        .NUM_REQ      (NUM_REQ),
        .BW_REQ_INDEX (BW_REQ_INDEX)
    ) u_picker (
        .req     (bus.req_inst_valid),
        .pointer (rr_pointer),
        .onehot  (pick_onehot),
        .index   (pick_index),
        .any     (pick_any)
    );

    assign pick_inst  = bus.req_inst_list[int'(pick_index)*BW_INST +: BW_INST];
    assign owner_inst = bus.req_inst_list[int'(owner)*BW_INST +: BW_INST];

    // A stalled cycle never completes a handshake, so no ready is lost.
    assign done = (state == ST_ISSUE) && bus.lsu_inst_ready && enable;
    assign can_lock = bus.req_lock[owner]
                   && (burst_count < BW_BURST'(MAX_BURST));
    assign next_pointer = (owner == BW_REQ_INDEX'(NUM_REQ - 1))
                        ? '0 : owner + 1'b1;

    assign bus.lsu_inst_valid = (state == ST_ISSUE);
    assign bus.lsu_inst       = inst_reg;
    assign bus.req_inst_ready = done ? grant : '0;
    assign bus.grant_onehot   = grant;
    assign bus.grant_index    = owner;
    assign bus.arb_busy       = (state != ST_IDLE);

    // Next-state and next-register values; everything holds when disabled.
    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        owner_nx      = owner;
        rr_pointer_nx = rr_pointer;
        burst_nx      = burst_count;
        inst_nx       = inst_reg;
        if (enable) begin
            unique case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state_nx = ST_WAIT_LSU;
                        grant_nx = pick_onehot;
                        owner_nx = pick_index;
                        inst_nx  = pick_inst;
                        burst_nx = BW_BURST'(1);
                    end
                end
                ST_WAIT_LSU: begin
                    if (!bus.lsu_busy) begin
                        state_nx = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (done) begin
                        if (can_lock) begin
                            state_nx = ST_RELOCK;
                        end else begin
                            state_nx      = ST_IDLE;
                            rr_pointer_nx = next_pointer;
                            grant_nx      = '0;
                            owner_nx      = '0;
                        end
                    end
                end
                ST_RELOCK: begin
                    if (bus.req_inst_valid[owner]) begin
                        state_nx = ST_WAIT_LSU;
                        inst_nx  = owner_inst;
                        if (burst_count < BW_BURST'(MAX_BURST)) begin
                            burst_nx = burst_count + 1'b1;
                        end
                    end else begin
                        state_nx      = ST_IDLE;
                        rr_pointer_nx = next_pointer;
                        grant_nx      = '0;
                        owner_nx      = '0;
                    end
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state       <= ST_IDLE;
            grant       <= '0;
            owner       <= '0;
            rr_pointer  <= '0;
            burst_count <= '0;
            inst_reg    <= '0;
        end else begin
            state       <= state_nx;
            grant       <= grant_nx;
            owner       <= owner_nx;
            rr_pointer  <= rr_pointer_nx;
            burst_count <= burst_nx;
            inst_reg    <= inst_nx;
        end
    end

endmodule

// File: tb/tb_dca_matrix_lsu_arbiter.sv
// Randomized and directed bench for dca_matrix_lsu_arbiter.
// A cycle-level behavioural model predicts every output.
module tb_dca_matrix_lsu_arbiter;
    import dca_matrix_lsu_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int W  = BW_DCA_MATRIX_LSU_INST;
    localparam int MB = 4;
    localparam int BI = req_index_bits(N);

    logic clk = 1'b0;
    logic rstnn = 1'b0;
    logic enable = 1'b0;

    dca_matrix_lsu_arbiter_if #(
        .NUM_REQ(N), .BW_INST(W), .BW_REQ_INDEX(BI)
    ) bus ();

    dca_matrix_lsu_arbiter #(
        .NUM_REQ(N), .BW_INST(W), .MAX_BURST(MB), .BW_REQ_INDEX(BI)
    ) dut (
        .clk    (clk),
        .rstnn  (rstnn),
        .enable (enable),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // stimulus state
    logic [N-1:0] s_valid, s_lock, refill;
    logic [W-1:0] s_inst [N];
    logic s_busy, s_lready, s_en;
    bit rand_mode;

    // reference model
    int m_owner, m_ptr, m_burst;
    bit m_issue, m_relock;
    logic [W-1:0] m_inst;
    int order[$];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int first_from(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic apply();
        bus.req_inst_valid = s_valid;
        for (int i = 0; i < N; i++) bus.req_inst_list[i*W +: W] = s_inst[i];
        bus.req_lock = s_lock;
        bus.lsu_busy = s_busy;
        bus.lsu_inst_ready = s_lready;
        enable = s_en;
    endtask

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_burst = 0;
        m_issue = 0; m_relock = 0; m_inst = '0;
    endtask

    task automatic model_release();
        m_ptr = (m_owner + 1) % N;
        m_owner = -1; m_issue = 0; m_relock = 0;
    endtask

    task automatic step();
        logic [N-1:0] eg, er;
        logic [BI-1:0] egi;
        bit done;
        int w;
        @(negedge clk);
        apply();
        #1;
        eg = '0; egi = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            egi = BI'(m_owner);
        end
        done = m_issue && s_lready && s_en;
        er = done ? eg : '0;
        check("lsu_valid", bus.lsu_inst_valid, m_issue);
        check("grant", bus.grant_onehot, eg);
        check("grant_idx", bus.grant_index, egi);
        check("arb_busy", bus.arb_busy, m_owner >= 0);
        check("req_ready", bus.req_inst_ready, er);
        if (m_issue) check("lsu_inst", bus.lsu_inst, m_inst);
        for (int i = 0; i < N; i++) if (bus.req_inst_ready[i]) order.push_back(i);
        if (s_en) begin
            if (m_owner < 0) begin
                w = first_from(s_valid, m_ptr);
                if (w >= 0) begin
                    m_owner = w; m_inst = s_inst[w]; m_burst = 1;
                end
            end else if (m_relock) begin
                if (s_valid[m_owner]) begin
                    m_inst = s_inst[m_owner];
                    m_burst = (m_burst < MB) ? m_burst + 1 : MB;
                    m_relock = 0;
                end else model_release();
            end else if (!m_issue) begin
                if (!s_busy) m_issue = 1;
            end else if (done) begin
                if (s_lock[m_owner] && m_burst < MB) begin
                    m_issue = 0; m_relock = 1;
                end else model_release();
            end
        end
        for (int i = 0; i < N; i++) begin
            if (er[i]) begin
                if (refill[i] || (rand_mode && $urandom_range(0, 1) == 1)) begin
                    s_inst[i] = $urandom; s_valid[i] = 1'b1;
                end else s_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        s_valid = '0; s_lock = '0; refill = '0;
        s_busy = 0; s_lready = 0; s_en = 1;
        apply();
        rstnn = 1'b0;
        #1;
        check("rst_valid", bus.lsu_inst_valid, 1'b0);
        check("rst_grant", bus.grant_onehot, '0);
        check("rst_busy", bus.arb_busy, 1'b0);
        check("rst_idx", bus.grant_index, '0);
        check("rst_ready", bus.req_inst_ready, '0);
        @(negedge clk);
        @(negedge clk);
        rstnn = 1'b1;
        model_reset();
        order.delete();
    endtask

    task automatic check_order(string tag, int exp[5], int cnt);
        for (int k = 0; k < cnt; k++) begin
            check(tag, (k < order.size()) ? order[k] : 99, exp[k]);
        end
    endtask

    int ex[5];

    initial begin
        for (int i = 0; i < N; i++) s_inst[i] = '0;
        rand_mode = 0;
        do_reset();

        // single request, LSU completes a few cycles after issue
        s_valid = 4'b0100; s_inst[2] = 32'hCAFE_0002;
        for (int k = 0; k < 7; k++) begin
            s_lready = (k == 5);
            step();
        end
        s_valid = 4'b1111; s_lready = 1;
        for (int k = 0; k < 5; k++) step();
        ex = '{2, 3, 0, 0, 0};
        check_order("single_order", ex, 2);

        // fairness without lock
        do_reset();
        s_valid = 4'b1111; refill = 4'b1111; s_lready = 1;
        for (int i = 0; i < N; i++) s_inst[i] = 32'h100 + i;
        for (int k = 0; k < 20; k++) step();
        ex = '{0, 1, 2, 3, 0};
        check_order("fair_order", ex, 5);

        // lock burst capped at MB
        do_reset();
        s_valid = 4'b1010; refill = 4'b1010; s_lock = 4'b0010; s_lready = 1;
        for (int k = 0; k < 24; k++) step();
        ex = '{1, 1, 1, 1, 3};
        check_order("burst_order", ex, 5);

        // lock without follow-up instruction
        do_reset();
        s_valid = 4'b0101; refill = 4'b0100; s_lock = 4'b0001; s_lready = 1;
        for (int k = 0; k < 12; k++) step();
        ex = '{0, 2, 2, 0, 0};
        check_order("nofollow_order", ex, 2);

        // LSU busy hold, then stall during issue
        do_reset();
        s_valid = 4'b0001; s_busy = 1;
        for (int k = 0; k < 11; k++) step();
        s_busy = 0; step(); step();
        s_lready = 1; s_en = 0;
        for (int k = 0; k < 3; k++) step();
        s_en = 1; step();
        check("en_ready_cnt", order.size(), 1);

        // async reset while issuing
        s_lready = 0; s_valid = 4'b0100; s_inst[2] = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) step();
        #2;
        do_reset();
        s_valid = 4'b1111; s_lready = 1;
        for (int k = 0; k < 4; k++) step();
        ex = '{0, 0, 0, 0, 0};
        check_order("post_rst_order", ex, 1);

        // randomized traffic
        do_reset();
        rand_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!s_valid[i] && $urandom_range(0, 3) == 0) begin
                    s_valid[i] = 1'b1; s_inst[i] = $urandom;
                end
            end
            s_lock = N'($urandom);
            s_busy = ($urandom_range(0, 3) == 0);
            s_lready = 1'($urandom_range(0, 1));
            s_en = ($urandom_range(0, 7) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
